// File: rtl/pong_pkg.sv
// Shared pong game constants, paddle FSM/direction types and the paddle step helper.
package pong_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int PADDLE_HEIGHT = 100;
  localparam int PADDLE_WIDTH  = 10;

  localparam logic [11:0] COLOUR_BLACK  = 12'h000;
  localparam logic [11:0] COLOUR_WHITE  = 12'hFFF;
  localparam logic [11:0] COLOUR_PADDLE = 12'h0F0;
  localparam logic [11:0] COLOUR_BALL   = 12'hFF0;

  typedef enum logic [1:0] {IDLE, MOVE_SLOW, MOVE_FAST} paddle_state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} paddle_dir_t;

  // 11-bit sum so a step near the bottom limit cannot wrap before saturating.
  function automatic logic [9:0] step_pos(input logic [9:0] pos, input paddle_dir_t dir,
                                          input logic [9:0] speed, input logic [9:0] max_pos);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, speed};
    case (dir)
      DIR_UP:   step_pos = (pos < speed) ? 10'd0 : pos - speed;
      DIR_DOWN: step_pos = (sum > {1'b0, max_pos}) ? max_pos : sum[9:0];
      default:  step_pos = pos;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for one active-low pushbutton.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock_25M,
  input  logic reset_n,
  input  logic btn_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] count;
  logic             raw_pressed;

  assign raw_pressed = ~sync_2;

  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
    end
  end

  // A level change is accepted only once it has held for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      pressed <= 1'b0;
    end else if (raw_pressed == pressed) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count   <= '0;
      pressed <= raw_pressed;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/paddle_controller.sv
// Turns two debounced pushbuttons into the paddle top row, updated once per frame
// with slow/fast speed and saturation at the screen limits.
module paddle_controller #(
  parameter int SCREEN_HEIGHT   = pong_pkg::SCREEN_HEIGHT,
  parameter int PADDLE_HEIGHT   = pong_pkg::PADDLE_HEIGHT,
  parameter int INIT_POS        = 190,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SPEED_SLOW      = 2,
  parameter int SPEED_FAST      = 6,
  parameter int HOLD_FRAMES     = 15
) (
  input  logic       clock_25M,
  input  logic       reset_n,
  input  logic       frame,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  output logic [9:0] pad_top_pixel,
  output logic       moving
);

  import pong_pkg::*;

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [9:0] MAX_POS   = 10'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [9:0] START_POS = 10'(INIT_POS);
  localparam logic [9:0] SLOW_STEP = 10'(SPEED_SLOW);
  localparam logic [9:0] FAST_STEP = 10'(SPEED_FAST);

  logic              up_pressed;
  logic              down_pressed;
  paddle_dir_t       dir;
  paddle_state_t     state;
  paddle_state_t     next_state;
  paddle_dir_t       last_dir;
  paddle_dir_t       next_last_dir;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] next_hold;
  logic              step_en;
  logic [9:0]        speed;
  logic [9:0]        next_pos;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_debouncer (
    .clock_25M (clock_25M),
    .reset_n   (reset_n),
    .btn_n     (btn_up_n),
    .pressed   (up_pressed)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_debouncer (
    .clock_25M (clock_25M),
    .reset_n   (reset_n),
    .btn_n     (btn_down_n),
    .pressed   (down_pressed)
  );

  always_comb begin
    dir = DIR_NONE;
    if (up_pressed && !down_pressed)      dir = DIR_UP;
    else if (down_pressed && !up_pressed) dir = DIR_DOWN;
  end

  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_dir      <= DIR_NONE;
      hold_cnt      <= '0;
      pad_top_pixel <= START_POS;
      moving        <= 1'b0;
    end else begin
      state         <= next_state;
      last_dir      <= next_last_dir;
      hold_cnt      <= next_hold;
      pad_top_pixel <= next_pos;
      moving        <= (next_state != IDLE);
    end
  end

  // A reversal without passing through NONE restarts the slow phase.
  always_comb begin
    next_state    = state;
    next_hold     = hold_cnt;
    next_last_dir = last_dir;
    step_en       = 1'b0;
    speed         = SLOW_STEP;
    if (frame) begin
      case (state)
        IDLE: begin
          if (dir != DIR_NONE) begin
            next_state = MOVE_SLOW;
            next_hold  = '0;
            step_en    = 1'b1;
          end
        end
        MOVE_SLOW, MOVE_FAST: begin
          if (dir == DIR_NONE) begin
            next_state = IDLE;
          end else if (dir != last_dir) begin
            next_state = MOVE_SLOW;
            next_hold  = '0;
            step_en    = 1'b1;
          end else if (state == MOVE_SLOW) begin
            step_en   = 1'b1;
            next_hold = hold_cnt + HOLD_W'(1);
            if (next_hold >= HOLD_LAST) next_state = MOVE_FAST;
          end else begin
            step_en = 1'b1;
            speed   = FAST_STEP;
          end
        end
        default: next_state = IDLE;
      endcase
      if (step_en) next_last_dir = dir;
    end
  end

  always_comb begin
    next_pos = pad_top_pixel;
    if (step_en) next_pos = step_pos(pad_top_pixel, dir, speed, MAX_POS);
  end

endmodule

// File: tb/tb_paddle_controller.sv
// Directed bench for paddle_controller with a short debounce and a frame pulse every 50 cycles.
module tb_paddle_controller;

  logic       clock_25M;
  logic       reset_n;
  logic       frame;
  logic       btn_up_n;
  logic       btn_down_n;
  logic [9:0] pad_top_pixel;
  logic       moving;

  int checkCount = 0;
  int passCount  = 0;

  paddle_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clock_25M     (clock_25M),
    .reset_n       (reset_n),
    .frame         (frame),
    .btn_up_n      (btn_up_n),
    .btn_down_n    (btn_down_n),
    .pad_top_pixel (pad_top_pixel),
    .moving        (moving)
  );

  initial clock_25M = 1'b0;
  always #5 clock_25M = ~clock_25M;

  initial begin
    frame = 1'b0;
    forever begin
      repeat (49) @(negedge clock_25M);
      frame = 1'b1;
      @(negedge clock_25M);
      frame = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic up_n, input logic down_n);
    btn_up_n   = up_n;
    btn_down_n = down_n;
  endtask

  // Returns #1 after the clock edge that sampled the next frame pulse.
  task automatic waitFrame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock_25M);
      if (frame) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    if (!seen) checkOutput("frame_timeout", 0, 1);
  endtask

  initial begin
    int expPos;
    bit stable;

    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1);
    repeat (3) @(negedge clock_25M);
    checkOutput("reset_pos", pad_top_pixel, 190);
    checkOutput("reset_moving", moving, 0);
    reset_n = 1'b1;
    waitFrame();
    waitFrame();
    checkOutput("idle_pos", pad_top_pixel, 190);
    checkOutput("idle_moving", moving, 0);

    $display("[TB] glitch rejection");
    @(negedge clock_25M);
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(negedge clock_25M);
    applyStimulus(1'b1, 1'b1);
    repeat (10) waitFrame();
    checkOutput("glitch_pos", pad_top_pixel, 190);
    checkOutput("glitch_moving", moving, 0);

    $display("[TB] acceleration and bottom saturation");
    applyStimulus(1'b1, 1'b0);
    expPos = 190;
    for (int k = 1; k <= 45; k++) begin
      waitFrame();
      expPos = expPos + ((k <= 15) ? 2 : 6);
      if (expPos > 380) expPos = 380;
      checkOutput($sformatf("down_pos_f%0d", k), pad_top_pixel, expPos);
      checkOutput($sformatf("down_moving_f%0d", k), moving, 1);
    end

    $display("[TB] both pressed while fast");
    applyStimulus(1'b0, 1'b0);
    waitFrame();
    checkOutput("both_pos", pad_top_pixel, 380);
    checkOutput("both_moving", moving, 0);
    applyStimulus(1'b0, 1'b1);
    expPos = 380;
    for (int k = 1; k <= 80; k++) begin
      waitFrame();
      expPos = expPos - ((k <= 15) ? 2 : 6);
      if (expPos < 0) expPos = 0;
      checkOutput($sformatf("up_pos_f%0d", k), pad_top_pixel, expPos);
      checkOutput($sformatf("up_moving_f%0d", k), moving, 1);
    end

    $display("[TB] reversal from fast");
    applyStimulus(1'b1, 1'b0);
    waitFrame();
    checkOutput("rev_pos_1", pad_top_pixel, 2);
    waitFrame();
    checkOutput("rev_pos_2", pad_top_pixel, 4);
    applyStimulus(1'b1, 1'b1);
    waitFrame();
    checkOutput("rev_stop_pos", pad_top_pixel, 4);
    checkOutput("rev_stop_moving", moving, 0);

    $display("[TB] frame gating");
    stable = 1'b1;
    repeat (20) begin
      @(negedge clock_25M);
      if (pad_top_pixel != 10'd4) stable = 1'b0;
    end
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clock_25M);
      if (frame) break;
      #1;
      if (pad_top_pixel != 10'd4) stable = 1'b0;
    end
    checkOutput("gate_before_frame", stable, 1);
    #1;
    checkOutput("gate_after_frame", pad_top_pixel, 6);
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock_25M);
      if (frame) break;
      #1;
      if (pad_top_pixel != 10'd6) stable = 1'b0;
    end
    checkOutput("gate_once_per_pulse", stable, 1);
    #1;
    checkOutput("gate_next_frame", pad_top_pixel, 8);

    $display("[TB] reset mid-run");
    repeat (10) @(negedge clock_25M);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_pos", pad_top_pixel, 190);
    checkOutput("midreset_moving", moving, 0);
    waitFrame();
    waitFrame();
    checkOutput("reset_frame_ignored", pad_top_pixel, 190);
    reset_n = 1'b1;
    waitFrame();
    checkOutput("post_reset_pos", pad_top_pixel, 192);
    checkOutput("post_reset_moving", moving, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
